// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register carrying PC, instruction, exception
// code, branch-delay flag and valid, with flush, exception redirect and stall count.
module pipe_stage_reg #(
  parameter int unsigned          PC_W     = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter int unsigned          EXC_W    = 5,
  parameter int unsigned          CNT_W    = 4,
  parameter logic [PC_W-1:0]      RESET_PC = 32'h0000_3000,
  parameter logic [PC_W-1:0]      REQ_PC   = 32'h0000_4180,
  parameter logic [INSTR_W-1:0]   NOP      = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               req,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               r_valid;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [EXC_W-1:0]   r_exc;
  logic               r_bd;
  logic [CNT_W-1:0]   r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_pc        <= RESET_PC;
      r_instr     <= NOP;
      r_exc       <= '0;
      r_bd        <= 1'b0;
      r_stall_cnt <= '0;
    end else if (req) begin
      r_valid     <= 1'b0;
      r_pc        <= REQ_PC;
      r_instr     <= NOP;
      r_exc       <= '0;
      r_bd        <= 1'b0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      // Bubble keeps PC/BD for EPC reporting; under stall the held PC/BD win.
      r_valid     <= 1'b0;
      r_instr     <= NOP;
      r_exc       <= '0;
      r_stall_cnt <= '0;
      if (!stall) begin
        r_pc <= in_pc;
        r_bd <= in_bd;
      end
    end else if (stall) begin
      if (r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_valid     <= in_valid;
      r_pc        <= in_pc;
      r_bd        <= in_bd;
      r_instr     <= in_valid ? in_instr : NOP;
      r_exc       <= in_valid ? in_exc : '0;
      r_stall_cnt <= '0;
    end
  end

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign out_instr = r_instr;
  assign out_exc   = r_exc;
  assign out_bd    = r_bd;
  assign stall_cnt = r_stall_cnt;

endmodule
